route_e_controller: RTL and testbench

Sequential route-setting controller for route E of the ring interlock. It sits directly downstream of the route-E interlock equation and consumes its permission output. It also drives the route-E request level back into the interlock. It sequences request check, points setting/proving, signal clearing, train passage and timed (approach-locked) cancellation, with a points-timeout fault.

---
 rtl/route_e_controller.sv | 108 ++++++++++
 tb/tb_route_e_controller.sv | 136 +++++++++++++
 2 files changed

// File: rtl/route_e_controller.sv
// Route-E setting controller: request check, points proving, signal clear,
// train passage and approach-locked cancellation with a points-timeout fault.
module route_e_controller #(
  parameter int POINT_TIMEOUT = 1000,
  parameter int RELEASE_DELAY = 500,
  parameter int TW            = 16
) (
  input  logic       i_Clk,
  input  logic       i_Rst_n,
  input  logic       i_Req,
  input  logic       i_Cancel,
  input  logic       i_Permit,
  input  logic       i_PointsDetected,
  input  logic       i_TrackOccupied,
  output logic       o_Set,
  output logic       o_PointsCall,
  output logic       o_Signal,
  output logic       o_Locked,
  output logic       o_Fault,
  output logic       o_Reject,
  output logic [2:0] o_State
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    CHECK      = 3'd1,
    SET_POINTS = 3'd2,
    CLEAR      = 3'd3,
    OCCUPIED   = 3'd4,
    APPROACH   = 3'd5,
    FAULT      = 3'd6
  } state_t;

  localparam logic [TW-1:0] PT_LAST = TW'(POINT_TIMEOUT - 1);
  localparam logic [TW-1:0] RD_LAST = TW'(RELEASE_DELAY - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic          reject;

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_n) begin
      state  <= IDLE;
      timer  <= '0;
      reject <= 1'b0;
    end else begin
      state  <= state_nxt;
      // Refusal is a permit miss in CHECK; cancel alone is not a reject.
      reject <= (state == CHECK) && !i_Permit;
      if (state_nxt != state || state == IDLE)
        timer <= '0;
      else if (timer != '1)
        timer <= timer + TW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (i_Req && !i_TrackOccupied) state_nxt = CHECK;
      CHECK: begin
        if (!i_Permit)     state_nxt = IDLE;
        else if (i_Cancel) state_nxt = IDLE;
        else               state_nxt = SET_POINTS;
      end
      SET_POINTS: begin
        if (i_Cancel)               state_nxt = IDLE;
        else if (i_PointsDetected)  state_nxt = CLEAR;
        else if (timer == PT_LAST)  state_nxt = FAULT;
      end
      CLEAR: begin
        if (i_TrackOccupied)                    state_nxt = OCCUPIED;
        else if (!i_PointsDetected || !i_Permit) state_nxt = FAULT;
        else if (i_Cancel)                      state_nxt = APPROACH;
      end
      OCCUPIED:   if (!i_TrackOccupied) state_nxt = IDLE;
      APPROACH: begin
        if (i_TrackOccupied)       state_nxt = OCCUPIED;
        else if (timer == RD_LAST) state_nxt = IDLE;
      end
      FAULT:      if (i_Cancel && !i_TrackOccupied) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_Set        = 1'b0;
    o_Locked     = 1'b0;
    o_PointsCall = 1'b0;
    o_Signal     = 1'b0;
    o_Fault      = 1'b0;
    case (state)
      CHECK:      o_Set = 1'b1;
      SET_POINTS: begin o_Set = 1'b1; o_Locked = 1'b1; o_PointsCall = 1'b1; end
      CLEAR: begin
        o_Set = 1'b1; o_Locked = 1'b1; o_PointsCall = 1'b1; o_Signal = 1'b1;
      end
      OCCUPIED,
      APPROACH:   o_Locked = 1'b1;
      FAULT:      begin o_Set = 1'b1; o_Locked = 1'b1; o_Fault = 1'b1; end
      default: ;
    endcase
  end

  assign o_Reject = reject;
  assign o_State  = state;

endmodule

// File: tb/tb_route_e_controller.sv
// Directed bench for route_e_controller with POINT_TIMEOUT=8, RELEASE_DELAY=5.
module tb_route_e_controller;

  logic       gclk = 1'b0;
  logic       rst_n, req, cancel, permit, pd, occ;
  logic       set_o, pc_o, sig_o, lock_o, fault_o, rej_o;
  logic [2:0] state_o;
  int         n_cmp = 0;
  int         n_err = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_CHECK = 3'd1, S_SP = 3'd2, S_CLEAR = 3'd3,
                         S_OCC = 3'd4, S_APP = 3'd5, S_FAULT = 3'd6;

  always #5 gclk = ~gclk;

  route_e_controller #(.POINT_TIMEOUT(8), .RELEASE_DELAY(5), .TW(16)) dut (
    .i_Clk(gclk), .i_Rst_n(rst_n), .i_Req(req), .i_Cancel(cancel),
    .i_Permit(permit), .i_PointsDetected(pd), .i_TrackOccupied(occ),
    .o_Set(set_o), .o_PointsCall(pc_o), .o_Signal(sig_o), .o_Locked(lock_o),
    .o_Fault(fault_o), .o_Reject(rej_o), .o_State(state_o)
  );

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (state,set,lock,pc,sig,fault,rej)", tag, obs, exp);
    end
  endtask

  // Hand table of expected outputs per state: {state,set,lock,pc,sig,fault,rej}
  function automatic logic [8:0] ev(input logic [2:0] s, input logic rej);
    logic [4:0] o;
    case (s)
      S_CHECK: o = 5'b10000;
      S_SP:    o = 5'b11100;
      S_CLEAR: o = 5'b11110;
      S_OCC:   o = 5'b01000;
      S_APP:   o = 5'b01000;
      S_FAULT: o = 5'b11001;
      default: o = 5'b00000;
    endcase
    return {s, o, rej};
  endfunction

  function automatic logic [8:0] obs();
    return {state_o, set_o, lock_o, pc_o, sig_o, fault_o, rej_o};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge gclk);
    #1;
  endtask

  // From IDLE with permit=1, pd=1, occ=0: reach CLEAR in three edges.
  task automatic to_clear(input string tag);
    req = 1; tick(1);
    req = 0; tick(2);
    chk(tag, obs(), ev(S_CLEAR, 0));
  endtask

  initial begin
    rst_n = 0; req = 1; cancel = 1; permit = 1; pd = 1; occ = 1;
    tick(2);
    chk("reset", obs(), ev(S_IDLE, 0));

    // Normal route
    rst_n = 1; req = 0; cancel = 0; occ = 0; pd = 0;
    tick(1); chk("rel_idle", obs(), ev(S_IDLE, 0));
    req = 1; tick(1); chk("req_check", obs(), ev(S_CHECK, 0));
    req = 0; tick(1); chk("set_points", obs(), ev(S_SP, 0));
    tick(2); chk("sp_wait", obs(), ev(S_SP, 0));
    pd = 1; tick(1); chk("clear", obs(), ev(S_CLEAR, 0));
    occ = 1; tick(1); chk("occupied", obs(), ev(S_OCC, 0));
    cancel = 1; tick(1); chk("occ_cancel_ign", obs(), ev(S_OCC, 0));
    cancel = 0; occ = 0; tick(1); chk("train_release", obs(), ev(S_IDLE, 0));

    // Rejection
    permit = 0; req = 1; tick(1); chk("rej_check", obs(), ev(S_CHECK, 0));
    req = 0; tick(1); chk("rej_pulse", obs(), ev(S_IDLE, 1));
    tick(1); chk("rej_end", obs(), ev(S_IDLE, 0));

    // Points timeout: FAULT exactly 8 edges after SET_POINTS entry
    permit = 1; pd = 0; req = 1; tick(1);
    req = 0; tick(1); chk("to_sp", obs(), ev(S_SP, 0));
    tick(7); chk("to_edge7", obs(), ev(S_SP, 0));
    tick(1); chk("to_fault", obs(), ev(S_FAULT, 0));
    cancel = 1; occ = 1; tick(2); chk("fault_sticky", obs(), ev(S_FAULT, 0));
    occ = 0; tick(1); chk("fault_clear", obs(), ev(S_IDLE, 0));
    cancel = 0; pd = 1;

    // Approach lock: release exactly 5 edges after APPROACH entry
    to_clear("app_clear");
    cancel = 1; tick(1); chk("app_enter", obs(), ev(S_APP, 0));
    cancel = 0; tick(4); chk("app_hold", obs(), ev(S_APP, 0));
    tick(1); chk("app_release", obs(), ev(S_IDLE, 0));

    to_clear("app2_clear");
    cancel = 1; tick(1);
    cancel = 0; tick(2); chk("app2_c3", obs(), ev(S_APP, 0));
    occ = 1; tick(1); chk("app2_occ", obs(), ev(S_OCC, 0));
    tick(4); chk("app2_norel", obs(), ev(S_OCC, 0));
    occ = 0; tick(1); chk("app2_idle", obs(), ev(S_IDLE, 0));

    // Mid-route faults
    to_clear("det_clear");
    pd = 0; tick(1); chk("det_loss", obs(), ev(S_FAULT, 0));
    cancel = 1; tick(1); chk("det_cancel", obs(), ev(S_IDLE, 0));
    cancel = 0; pd = 1;
    to_clear("perm_clear");
    permit = 0; tick(1); chk("perm_loss", obs(), ev(S_FAULT, 0));
    cancel = 1; tick(1);
    cancel = 0; permit = 1;
    to_clear("rst_clear");
    rst_n = 0; tick(1); chk("rst_mid", obs(), ev(S_IDLE, 0));
    rst_n = 1;

    // Cancel while setting points: straight back to IDLE
    pd = 0; req = 1; tick(1); req = 0; tick(1);
    cancel = 1; tick(1); chk("sp_cancel", obs(), ev(S_IDLE, 0));
    cancel = 0; pd = 1;

    // Simultaneous req+cancel in IDLE: request wins, cancel then acts in CHECK
    req = 1; cancel = 1; tick(1); chk("req_cancel", obs(), ev(S_CHECK, 0));
    req = 0; tick(1); chk("check_cancel", obs(), ev(S_IDLE, 0));
    cancel = 0;

    // Occupied track blocks a request
    occ = 1; req = 1; tick(1); chk("occ_block", obs(), ev(S_IDLE, 0));
    req = 0; occ = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
